// File: rtl/terrain_pkg.sv
// terrain_pkg: constants and types shared by terrain_gen, the terrain store,
// collider and color_mapper.
//   COLS / ROWS / WORD_W : map geometry (columns, visible rows, column word)
//   tgen_state_t         : generator sequencing states
//   column_t             : one column bitmap, bit r = row r (row 0 = top)
//   clamp_s11            : saturate an 11-bit signed value into [lo, hi]
package terrain_pkg;

  localparam int unsigned COLS     = 640;
  localparam int unsigned ROWS     = 480;
  localparam int unsigned WORD_W   = 512;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned HEIGHT_W = 10;

  typedef enum logic [1:0] {IDLE, STEP, WRITE, FIN} tgen_state_t;

  typedef logic [WORD_W-1:0] column_t;

  // Saturating clamp on signed 11-bit height arithmetic.
  function automatic logic signed [10:0] clamp_s11(
    input logic signed [10:0] v,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    logic signed [10:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/terrain_column_mask.sv
// terrain_column_mask: combinational height -> column bitmap encoder.
// Ports:
//   height : ground height in pixels (0..1023)
//   mask   : bit r set iff r < ROWS and r >= ROWS - height; bits >= ROWS clear
module terrain_column_mask #(
  parameter int unsigned ROWS   = 480,
  parameter int unsigned WORD_W = 512
) (
  input  logic [9:0]        height,
  output logic [WORD_W-1:0] mask
);
  import terrain_pkg::*;

  // Per-bit threshold compare; r + height >= ROWS avoids negative ROWS-height.
  always_comb begin
    mask = '0;
    for (int r = 0; r < int'(WORD_W); r++) begin
      if ((r < int'(ROWS)) && ((r + int'(height)) >= int'(ROWS))) begin
        mask[r] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/terrain_gen.sv
// terrain_gen: builds a random-walk height profile on each start and writes
// one column bitmap per two cycles into the terrain store.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : one-cycle regenerate request, honoured only in IDLE
//   rng             : PRNG word, low nibble used as signed step on STEP edges
//   busy            : generation in progress (STEP/WRITE)
//   done            : level, set after a full map, cleared on next accepted start
//   we              : one-cycle write strobe to the store
//   write_addr      : column being written
//   terrain_in      : column bitmap for write_addr
//   cur_height      : height of the column being written
module terrain_gen #(
  parameter int unsigned COLS     = 640,
  parameter int unsigned ROWS     = 480,
  parameter int unsigned WORD_W   = 512,
  parameter int unsigned H_INIT   = 120,
  parameter int unsigned H_MIN    = 40,
  parameter int unsigned H_MAX    = 360,
  parameter int unsigned MAX_STEP = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        rng,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [9:0]        write_addr,
  output logic [WORD_W-1:0] terrain_in,
  output logic [9:0]        cur_height
);
  import terrain_pkg::*;

  localparam logic [9:0]         LP_LAST   = 10'(COLS - 1);
  localparam logic [9:0]         LP_HINIT  = 10'(H_INIT);
  localparam logic signed [10:0] LP_STEP_P = 11'(MAX_STEP);
  localparam logic signed [10:0] LP_STEP_N = -LP_STEP_P;
  localparam logic signed [10:0] LP_HMIN   = 11'(H_MIN);
  localparam logic signed [10:0] LP_HMAX   = 11'(H_MAX);

  tgen_state_t       r_state;
  tgen_state_t       w_state_nxt;
  logic              r_busy,   w_busy_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_we,     w_we_nxt;
  logic [9:0]        r_addr,   w_addr_nxt;
  logic [9:0]        r_height, w_height_nxt;
  logic [WORD_W-1:0] r_column, w_column_nxt;

  logic signed [10:0] w_prev;
  logic signed [10:0] w_delta_raw;
  logic signed [10:0] w_delta;
  logic signed [10:0] w_sum;
  logic signed [10:0] w_clamped;
  logic [9:0]         w_height_new;
  logic [WORD_W-1:0]  w_mask;
  logic               w_unused_rng;

  // Only the low nibble of the PRNG word steers the walk.
  assign w_unused_rng = ^rng[9:4];

  // Next height: column 0 is fixed, later columns take a clamped signed step.
  always_comb begin
    w_prev       = {1'b0, r_height};
    w_delta_raw  = {{7{rng[3]}}, rng[3:0]};
    w_delta      = clamp_s11(w_delta_raw, LP_STEP_N, LP_STEP_P);
    w_sum        = w_prev + w_delta;
    w_clamped    = clamp_s11(w_sum, LP_HMIN, LP_HMAX);
    w_height_new = 10'(w_clamped);
    // write_addr is zeroed on start, so address 0 in STEP marks column 0.
    if (r_addr == 10'd0) begin
      w_height_new = LP_HINIT;
    end
  end

  // Bitmap of the height being registered this STEP.
  terrain_column_mask #(
    .ROWS   (ROWS),
    .WORD_W (WORD_W)
  ) u_mask (
    .height (w_height_new),
    .mask   (w_mask)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_height_nxt = r_height;
    w_column_nxt = r_column;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = STEP;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_addr_nxt  = 10'd0;
        end
      end
      STEP: begin
        w_state_nxt  = WRITE;
        w_we_nxt     = 1'b1;
        w_height_nxt = w_height_new;
        w_column_nxt = w_mask;
      end
      WRITE: begin
        if (r_addr == LP_LAST) begin
          w_state_nxt = FIN;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = STEP;
          w_addr_nxt  = r_addr + 10'd1;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 10'd0;
      r_height <= LP_HINIT;
      r_column <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_height <= w_height_nxt;
      r_column <= w_column_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign we         = r_we;
  assign write_addr = r_addr;
  assign terrain_in = r_column;
  assign cur_height = r_height;

endmodule
